inst_fetch_stage: RTL and testbench

//  IF stage of the MIPS 5-stage pipeline. Owns the PC and fetches words from instruction memory

---
 rtl/inst_fetch_stage.sv | 149 ++++++++++++++
 tb/tb_inst_fetch_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_stage.sv
// MIPS IF stage: PC, imem req/ack fetch, IF/ID register, stall hold buffer, redirect kill.
// Optional macro IF_STATIC_JUMP_EN resolves J/JAL targets in IF and tags them if_id_jumped.
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        stall_id,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_jumped
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } state_t;

  state_t      state;
  logic        kill;
  logic [31:0] pc;
  logic [31:0] buf_inst;
  logic [31:0] buf_pc;
  logic        buf_jmp;

  logic [31:0] addr4;
  logic [31:0] pc_next;
  logic [31:0] new_pc;
  logic        jmp;
  logic        take;
  logic        flow;
  logic        unused_rpc;

  assign unused_rpc = ^redirect_pc[1:0];
  assign new_pc     = {redirect_pc[31:2], 2'b00};

  always_comb begin
    addr4   = imem_addr + 32'd4;
    jmp     = 1'b0;
    pc_next = addr4;
`ifdef IF_STATIC_JUMP_EN
    if (imem_rdata[31:27] == 5'b00001) begin
      jmp     = 1'b1;
      pc_next = {addr4[31:28], imem_rdata[25:0], 2'b00};
    end
`else
    jmp     = 1'b0;
`endif
    take = imem_req & imem_ack;
    flow = en & (~stall_id | ~if_id_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      kill         <= 1'b0;
      pc           <= RESET_PC;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      if_id_valid  <= 1'b0;
      if_id_inst   <= 32'h0;
      if_id_pc     <= 32'h0;
      if_id_pc4    <= 32'h0;
      if_id_jumped <= 1'b0;
      buf_inst     <= 32'h0;
      buf_pc       <= 32'h0;
      buf_jmp      <= 1'b0;
    end else if (redirect) begin
      pc           <= new_pc;
      state        <= REQ;
      if_id_valid  <= 1'b0;
      if_id_inst   <= 32'h0;
      if_id_jumped <= 1'b0;
      // an in-flight request must finish before the new pc can go out
      if (imem_req && !imem_ack) begin
        kill <= 1'b1;
      end else begin
        kill      <= 1'b0;
        imem_req  <= en;
        imem_addr <= new_pc;
      end
    end else if (take && kill) begin
      kill      <= 1'b0;
      imem_req  <= en;
      imem_addr <= pc;
    end else if (take) begin
      pc <= pc_next;
      if (flow) begin
        if_id_valid  <= 1'b1;
        if_id_inst   <= imem_rdata;
        if_id_pc     <= imem_addr;
        if_id_pc4    <= addr4;
        if_id_jumped <= jmp;
        imem_addr    <= pc_next;
      end else begin
        buf_inst <= imem_rdata;
        buf_pc   <= imem_addr;
        buf_jmp  <= jmp;
        imem_req <= 1'b0;
        state    <= HOLD;
      end
    end else begin
      if (en && !stall_id && state != HOLD) begin
        if_id_valid  <= 1'b0;
        if_id_inst   <= 32'h0;
        if_id_jumped <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (en) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
        end
        REQ: begin
          if (en && !imem_req) begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
        end
        HOLD: begin
          if (en && !stall_id) begin
            if_id_valid  <= 1'b1;
            if_id_inst   <= buf_inst;
            if_id_pc     <= buf_pc;
            if_id_pc4    <= buf_pc + 32'd4;
            if_id_jumped <= buf_jmp;
            state        <= REQ;
            imem_req     <= 1'b1;
            imem_addr    <= pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Bench for inst_fetch_stage: directed fetch scenarios plus a randomized run
// checked against an in-order instruction stream model.
module tb_inst_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        stall_id;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic        if_id_jumped;

  int checks = 0;
  int errors = 0;

  inst_fetch_stage #(.RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .stall_id(stall_id),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid),
    .if_id_inst(if_id_inst),
    .if_id_pc(if_id_pc),
    .if_id_pc4(if_id_pc4),
    .if_id_jumped(if_id_jumped)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h0810_0004;
    return {6'b100011, a[27:2] ^ 26'h2A5_5A5A};
  endfunction

  task automatic tick(input bit ack_want);
    imem_ack   = ack_want & imem_req;
    imem_rdata = mem(imem_addr);
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1; en = 1'b0; stall_id = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0;
    tick(0);
    tick(0);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0h want 0", imem_req); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h want 0", if_id_valid); end
    checks++; if (if_id_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 0", if_id_inst); end
    checks++; if (if_id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", if_id_pc); end
    checks++; if (if_id_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h want 0", if_id_pc4); end
    checks++; if (if_id_jumped !== 1'b0) begin errors++; $display("FAIL reset_jumped got %0h want 0", if_id_jumped); end
    en = 1'b1;
    tick(0);
    tick(0);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_pre_req got %0h want 1", imem_req); end
    rst = 1'b1;
    tick(0);
    rst = 1'b0;
    en = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_kills_req got %0h want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_addr); end
  endtask

  task automatic test_stream;
    do_reset;
    en = 1'b1;
    tick(1);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL stream_first got %0h/%h want 1/0", imem_req, imem_addr); end
    for (int i = 0; i < 6; i++) begin
      tick(1);
      checks++; if (imem_addr !== 32'(4 * (i + 1))) begin errors++; $display("FAIL stream_addr got %h want %h", imem_addr, 4 * (i + 1)); end
      checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc got %0h/%h want 1/%h", if_id_valid, if_id_pc, 4 * i); end
      checks++; if (if_id_pc4 !== 32'(4 * i + 4)) begin errors++; $display("FAIL stream_pc4 got %h want %h", if_id_pc4, 4 * i + 4); end
      checks++; if (if_id_inst !== mem(32'(4 * i))) begin errors++; $display("FAIL stream_inst got %h want %h", if_id_inst, mem(32'(4 * i))); end
    end
  endtask

  task automatic test_ack_delay;
    do_reset;
    en = 1'b1;
    tick(1); tick(1); tick(1);
    for (int k = 0; k < 3; k++) begin
      tick(0);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL delay_hold got %0h/%h want 1/8", imem_req, imem_addr); end
      checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL delay_bubble got %0h want 0", if_id_valid); end
    end
    tick(1);
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h8) begin errors++; $display("FAIL delay_load got %0h/%h want 1/8", if_id_valid, if_id_pc); end
    checks++; if (if_id_inst !== mem(32'h8)) begin errors++; $display("FAIL delay_inst got %h want %h", if_id_inst, mem(32'h8)); end
    checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL delay_next got %h want c", imem_addr); end
  endtask

  task automatic test_stall;
    do_reset;
    en = 1'b1;
    for (int k = 0; k < 5; k++) tick(1);
    checks++; if (imem_addr !== 32'h10 || if_id_pc !== 32'hC) begin errors++; $display("FAIL stall_setup got %h/%h want 10/c", imem_addr, if_id_pc); end
    stall_id = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'hC) begin errors++; $display("FAIL stall_hold got %0h/%h want 1/c", if_id_valid, if_id_pc); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req got %0h want 0", imem_req); end
    end
    stall_id = 1'b0;
    tick(1);
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h10) begin errors++; $display("FAIL stall_release got %0h/%h want 1/10", if_id_valid, if_id_pc); end
    checks++; if (if_id_inst !== mem(32'h10)) begin errors++; $display("FAIL stall_inst got %h want %h", if_id_inst, mem(32'h10)); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin errors++; $display("FAIL stall_next got %0h/%h want 1/14", imem_req, imem_addr); end
  endtask

  task automatic test_redirect;
    do_reset;
    en = 1'b1;
    for (int k = 0; k < 9; k++) tick(1);
    checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL redir_setup got %h want 20", imem_addr); end
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick(0);
    redirect = 1'b0;
    checks++; if (if_id_valid !== 1'b0 || if_id_inst !== 32'h0) begin errors++; $display("FAIL redir_flush got %0h/%h want 0/0", if_id_valid, if_id_inst); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin errors++; $display("FAIL redir_keep got %0h/%h want 1/20", imem_req, imem_addr); end
    tick(1);
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL redir_discard got %0h want 0", if_id_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL redir_new got %0h/%h want 1/100", imem_req, imem_addr); end
    tick(1);
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100) begin errors++; $display("FAIL redir_load got %0h/%h want 1/100", if_id_valid, if_id_pc); end
    redirect = 1'b1; redirect_pc = 32'h0000_0202;
    tick(1);
    redirect = 1'b0;
    checks++; if (if_id_valid !== 1'b0 || imem_addr !== 32'h200) begin errors++; $display("FAIL redir_same got %0h/%h want 0/200", if_id_valid, imem_addr); end
    tick(1);
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h200) begin errors++; $display("FAIL redir_same_load got %0h/%h want 1/200", if_id_valid, if_id_pc); end
  endtask

  task automatic test_wrap;
    do_reset;
    en = 1'b1;
    tick(1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(1);
    redirect = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup got %h want fffffffc", imem_addr); end
    tick(1);
    checks++; if (if_id_pc !== 32'hFFFF_FFFC || if_id_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_ifid got %h/%h want fffffffc/0", if_id_pc, if_id_pc4); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h want 0", imem_addr); end
  endtask

  task automatic test_jump;
    logic [31:0] exp_addr;
    logic        exp_j;
`ifdef IF_STATIC_JUMP_EN
    exp_addr = 32'h0040_0010; exp_j = 1'b1;
`else
    exp_addr = 32'h0040_0004; exp_j = 1'b0;
`endif
    do_reset;
    en = 1'b1;
    tick(1);
    redirect = 1'b1; redirect_pc = 32'h0040_0000;
    tick(1);
    redirect = 1'b0;
    tick(1);
    checks++; if (if_id_inst !== 32'h0810_0004) begin errors++; $display("FAIL jump_inst got %h want 08100004", if_id_inst); end
    checks++; if (if_id_jumped !== exp_j) begin errors++; $display("FAIL jump_tag got %0h want %0h", if_id_jumped, exp_j); end
    checks++; if (imem_addr !== exp_addr) begin errors++; $display("FAIL jump_addr got %h want %h", imem_addr, exp_addr); end
  endtask

  task automatic test_random;
    logic [31:0] exp_pc;
    int          consumed;
    logic        s_req, s_ack, s_en, s_stall, s_redir, s_valid;
    logic [31:0] s_addr, s_inst, s_pc, s_pc4, s_rpc;
    do_reset;
    exp_pc = 32'h0;
    consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(0, 99) < 85);
      stall_id = ($urandom_range(0, 99) < 25);
      redirect = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 9) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else redirect_pc = $urandom & 32'h0000_FFFF;
      imem_ack = imem_req & ($urandom_range(0, 2) != 0);
      imem_rdata = mem(imem_addr);
      s_req = imem_req; s_ack = imem_ack; s_addr = imem_addr;
      s_en = en; s_stall = stall_id; s_redir = redirect; s_rpc = redirect_pc;
      s_valid = if_id_valid; s_inst = if_id_inst; s_pc = if_id_pc; s_pc4 = if_id_pc4;
      @(posedge clk);
      #1;
      if (imem_req) begin
        checks++; if (imem_addr[1:0] !== 2'b00) begin errors++; $display("FAIL rnd_align got %h want xxxxxxx0", imem_addr); end
      end
      if (s_req && !s_ack) begin
        checks++; if (imem_req !== 1'b1 || imem_addr !== s_addr) begin errors++; $display("FAIL rnd_stable got %0h/%h want 1/%h", imem_req, imem_addr, s_addr); end
      end
      if (!s_req && !s_en) begin
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rnd_freeze_req got %0h want 0", imem_req); end
      end
      if (s_redir) begin
        checks++; if (if_id_valid !== 1'b0 || if_id_inst !== 32'h0) begin errors++; $display("FAIL rnd_flush got %0h/%h want 0/0", if_id_valid, if_id_inst); end
        exp_pc = {s_rpc[31:2], 2'b00};
      end else begin
        if (s_valid && s_en && !s_stall) begin
          consumed++;
          checks++; if (s_pc !== exp_pc) begin errors++; $display("FAIL rnd_order got %h want %h", s_pc, exp_pc); end
          checks++; if (s_inst !== mem(s_pc) || s_pc4 !== s_pc + 32'd4) begin errors++; $display("FAIL rnd_data got %h/%h want %h/%h", s_inst, s_pc4, mem(s_pc), s_pc + 32'd4); end
          exp_pc = s_pc + 32'd4;
        end
        if (!s_en || (s_stall && s_valid)) begin
          checks++;
          if (if_id_valid !== s_valid || if_id_inst !== s_inst || if_id_pc !== s_pc || if_id_pc4 !== s_pc4) begin
            errors++; $display("FAIL rnd_hold got %0h/%h/%h want %0h/%h/%h", if_id_valid, if_id_inst, if_id_pc, s_valid, s_inst, s_pc);
          end
        end
      end
      if (!if_id_valid) begin
        checks++; if (if_id_inst !== 32'h0) begin errors++; $display("FAIL rnd_nop got %h want 0", if_id_inst); end
      end
    end
    en = 1'b0; stall_id = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
    checks++; if (consumed < 300) begin errors++; $display("FAIL rnd_progress got %0d want >=300", consumed); end
  endtask

  initial begin
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    test_reset;
    test_stream;
    test_ack_delay;
    test_stall;
    test_redirect;
    test_wrap;
    test_jump;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
